// File: rtl/sa_ram_fifo_pkg.sv
// Shared geometry and types for the 16x256 RAM-backed FIFO.
package sa_ram_fifo_pkg;
  localparam int DEPTH = 16;
  localparam int WIDTH = 256;
  localparam int AW    = 4;
  localparam int CW    = 5;

  typedef logic [AW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  localparam ptr_t PTR_ONE  = ptr_t'(1);
  localparam cnt_t CNT_ONE  = cnt_t'(1);
  localparam cnt_t FULL_CNT = cnt_t'(DEPTH);
endpackage

// File: rtl/sa_ram_fifo_16x256_rwsp.sv
// 16x256 single-port-style RAM: registered read address (re) and registered
// output (ore), independent write port. Contents are never reset.
module sa_ram_rwsp_16x256
  import sa_ram_fifo_pkg::*;
(
  input  logic             clk,
  input  logic             re_i,
  input  ptr_t             ra_i,
  input  logic             ore_i,
  input  logic             we_i,
  input  ptr_t             wa_i,
  input  logic [WIDTH-1:0] di_i,
  input  logic [31:0]      pwrbus_ram_pd_i,
  output logic [WIDTH-1:0] dout_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  ptr_t             ra_q;
  logic [WIDTH-1:0] dout_q;

  // Power-domain control is a behavioural no-op here.
  logic unused_pd;
  assign unused_pd = ^pwrbus_ram_pd_i;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[wa_i] <= di_i;
    if (re_i) ra_q <= ra_i;
    if (ore_i) dout_q <= mem_q[ra_q];
  end

  assign dout_o = dout_q;

endmodule

// File: rtl/sa_ram_fifo_16x256.sv
// Valid/ready FIFO over a 16x256 RAM with a 2-stage read pipeline.
// Optional occupancy output fifo_lvl is enabled by defining SA_RAM_FIFO_LVL_EN.
module sa_ram_fifo_16x256
  import sa_ram_fifo_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic [31:0]      pwrbus_ram_pd
`ifdef SA_RAM_FIFO_LVL_EN
  ,
  output logic [CW-1:0]    fifo_lvl
`endif
);

  ptr_t wp_q, wp_d, ip_q, ip_d, rp_q, rp_d;
  cnt_t cnt_q, cnt_d, pend_q, pend_d;
  logic s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d;
  logic push, re, ore;

  // cnt covers RAM plus S1; the S2 entry has already been released.
  assign in_ready  = (cnt_q != FULL_CNT);
  assign push      = in_valid & in_ready;
  assign ore       = s1_vld_q & (~s2_vld_q | out_ready);
  assign re        = ((ip_q != wp_q) | (pend_q != '0)) & (~s1_vld_q | ore);
  assign out_valid = s2_vld_q;

  always_comb begin
    wp_d     = push ? wp_q + PTR_ONE : wp_q;
    ip_d     = re   ? ip_q + PTR_ONE : ip_q;
    rp_d     = ore  ? rp_q + PTR_ONE : rp_q;
    s1_vld_d = re  | (s1_vld_q & ~ore);
    s2_vld_d = ore | (s2_vld_q & ~out_ready);

    cnt_d = cnt_q;
    case ({push, ore})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase

    // pend tells 16 outstanding issues apart from none when ip == wp.
    pend_d = pend_q;
    case ({push, re})
      2'b10:   pend_d = pend_q + CNT_ONE;
      2'b01:   pend_d = pend_q - CNT_ONE;
      default: pend_d = pend_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q     <= '0;
      ip_q     <= '0;
      rp_q     <= '0;
      cnt_q    <= '0;
      pend_q   <= '0;
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
    end else begin
      wp_q     <= wp_d;
      ip_q     <= ip_d;
      rp_q     <= rp_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      s1_vld_q <= s1_vld_d;
      s2_vld_q <= s2_vld_d;
    end
  end

`ifdef SA_RAM_FIFO_LVL_EN
  cnt_t lvl_q, lvl_d;

  assign lvl_d    = cnt_d + {{(CW-1){1'b0}}, s2_vld_d};
  assign fifo_lvl = lvl_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lvl_q <= '0;
    else     lvl_q <= lvl_d;
  end
`endif

  sa_ram_rwsp_16x256 u_ram (
    .clk             (clk),
    .re_i            (re),
    .ra_i            (ip_q),
    .ore_i           (ore),
    .we_i            (push),
    .wa_i            (wp_q),
    .di_i            (in_data),
    .pwrbus_ram_pd_i (pwrbus_ram_pd),
    .dout_o          (out_data)
  );

endmodule

// File: tb/tb_sa_ram_fifo_16x256.sv
// Directed self-checking bench for sa_ram_fifo_16x256 (fifo_lvl checks
// are included when SA_RAM_FIFO_LVL_EN is defined).
module tb_sa_ram_fifo_16x256;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [255:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] out_data;
  logic [31:0]  pwrbus_ram_pd;
`ifdef SA_RAM_FIFO_LVL_EN
  logic [4:0]   fifo_lvl;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sa_ram_fifo_16x256 dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .pwrbus_ram_pd (pwrbus_ram_pd)
`ifdef SA_RAM_FIFO_LVL_EN
    ,
    .fifo_lvl      (fifo_lvl)
`endif
  );

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    pwrbus_ram_pd = 32'h0;
    repeat (3) cyc();
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
`ifdef SA_RAM_FIFO_LVL_EN
    n_checks++;
    if (fifo_lvl !== 5'd0) begin n_fail++; $display("FAIL reset_lvl: got %0d want 0", fifo_lvl); end
`endif
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_single();
    logic [255:0] pat;
    pat = {32{8'hA5}};
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = pat;
    cyc();
    in_valid = 1'b0; in_data = '0;
    for (int k = 1; k <= 5; k++) begin
      n_checks++;
      if (out_valid !== (k == 3)) begin
        n_fail++; $display("FAIL single_valid_c%0d: got %0b want %0b", k, out_valid, (k == 3));
      end
      if (k == 3) begin
        n_checks++;
        if (out_data !== pat) begin n_fail++; $display("FAIL single_data: got %h want %h", out_data, pat); end
      end
      cyc();
    end
  endtask

  task automatic test_fill();
    int accepted, k;
    out_ready = 1'b0;
    accepted = 0;
    for (int i = 0; i < 18; i++) begin
      in_valid = 1'b1; in_data = 256'(i);
      k = 0;
      while (in_ready !== 1'b1 && k < 8) begin cyc(); k++; end
      if (in_ready === 1'b1) begin accepted++; cyc(); end
    end
    n_checks++;
    if (accepted != 17) begin n_fail++; $display("FAIL fill_accepted: got %0d want 17", accepted); end
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_in_ready: got %0b want 0", in_ready); end
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 256'd0) begin
      n_fail++; $display("FAIL fill_head: got valid=%0b data=%0d want valid=1 data=0", out_valid, out_data);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int j = 0; j < 17; j++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 256'(j)) begin
        n_fail++; $display("FAIL fill_drain_%0d: got valid=%0b data=%0d want valid=1 data=%0d", j, out_valid, out_data, j);
      end
      if (j == 1) begin
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready_rise: got %0b want 1", in_ready); end
      end
      cyc();
    end
    for (int k2 = 0; k2 < 3; k2++) begin
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fill_no_extra_%0d: got valid=%0b data=%0d want valid=0", k2, out_valid, out_data); end
      cyc();
    end
  endtask

  task automatic test_back_to_back();
    logic expv;
    out_ready = 1'b1;
    for (int c = 0; c < 46; c++) begin
      expv = (c >= 3) && (c < 43);
      n_checks++;
      if (out_valid !== expv) begin n_fail++; $display("FAIL stream_valid_c%0d: got %0b want %0b", c, out_valid, expv); end
      if (expv) begin
        n_checks++;
        if (out_data !== 256'(100 + c - 3)) begin
          n_fail++; $display("FAIL stream_data_c%0d: got %0d want %0d", c, out_data, 100 + c - 3);
        end
      end
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready_c%0d: got %0b want 1", c, in_ready); end
      in_valid = (c < 40);
      in_data  = 256'(100 + c);
      cyc();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    int sent, popped;
    logic prev_stall;
    logic [255:0] prev_data;
    sent = 0; popped = 0; prev_stall = 1'b0; prev_data = '0;
    for (int c = 0; c < 120 && popped < 20; c++) begin
      if (prev_stall) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== prev_data) begin
          n_fail++; $display("FAIL bp_stable_c%0d: got valid=%0b data=%0d want valid=1 data=%0d", c, out_valid, out_data, prev_data);
        end
      end
      out_ready = c[0];
      if (out_valid === 1'b1 && out_ready) begin
        n_checks++;
        if (out_data !== 256'(200 + popped)) begin
          n_fail++; $display("FAIL bp_order_%0d: got %0d want %0d", popped, out_data, 200 + popped);
        end
        popped++;
      end
      prev_stall = (out_valid === 1'b1) && !out_ready;
      prev_data  = out_data;
      if (sent < 20) begin
        in_valid = 1'b1; in_data = 256'(200 + sent);
        if (in_ready === 1'b1) sent++;
      end else begin
        in_valid = 1'b0;
      end
      cyc();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_checks++;
    if (popped != 20) begin n_fail++; $display("FAIL bp_count: got %0d want 20", popped); end
    repeat (4) cyc();
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_dup: got valid=%0b data=%0d want valid=0", out_valid, out_data); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 256'(300 + i);
      cyc();
    end
    in_valid = 1'b0;
    repeat (2) cyc();
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 256'd300) begin
      n_fail++; $display("FAIL rmid_pre: got valid=%0b data=%0d want valid=1 data=300", out_valid, out_data);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_out_valid: got %0b want 0", out_valid); end
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_in_ready: got %0b want 1", in_ready); end
    cyc();
    rst = 1'b0; out_ready = 1'b1;
    cyc();
    in_valid = 1'b1; in_data = 256'd1;
    cyc();
    in_valid = 1'b0; in_data = '0;
    for (int k = 1; k <= 6; k++) begin
      n_checks++;
      if (out_valid !== (k == 3)) begin
        n_fail++; $display("FAIL rmid_valid_c%0d: got %0b want %0b", k, out_valid, (k == 3));
      end
      if (k == 3) begin
        n_checks++;
        if (out_data !== 256'd1) begin n_fail++; $display("FAIL rmid_data: got %0d want 1", out_data); end
      end
      cyc();
    end
  endtask

`ifdef SA_RAM_FIFO_LVL_EN
  task automatic test_lvl();
    int k;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 256'(400 + i);
      cyc();
      n_checks++;
      if (fifo_lvl !== 5'(i + 1)) begin n_fail++; $display("FAIL lvl_push_%0d: got %0d want %0d", i, fifo_lvl, i + 1); end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    n_checks++;
    if (fifo_lvl !== 5'd2) begin n_fail++; $display("FAIL lvl_pop: got %0d want 2", fifo_lvl); end
    k = 0;
    while (in_ready === 1'b1 && k < 30) begin
      in_valid = 1'b1; in_data = 256'(500 + k);
      cyc(); k++;
    end
    in_valid = 1'b0;
    cyc();
    n_checks++;
    if (fifo_lvl !== 5'd17) begin n_fail++; $display("FAIL lvl_full: got %0d want 17", fifo_lvl); end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_backpressure();
`ifdef SA_RAM_FIFO_LVL_EN
    test_lvl();
`endif
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sa_ram_fifo_16x256.md
SA_RAM_FIFO_16X256 -- requirements
Module: sa_ram_fifo_16x256

Interface
REQ-001 SHALL have no module parameters; geometry comes from package constants DEPTH=16, WIDTH=256, AW=4, CW=5.
REQ-002 SHALL have port: clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port: in_valid  input  1  producer offers in_data.
REQ-005 SHALL have port: in_ready  output  1  FIFO accepts; push = in_valid & in_ready.
REQ-006 SHALL have port: in_data  input  256  push payload.
REQ-007 SHALL have port: out_valid  output  1  out_data holds the head entry.
REQ-008 SHALL have port: out_ready  input  1  consumer takes; pop = out_valid & out_ready.
REQ-009 SHALL have port: out_data  output  256  head payload; undefined while out_valid=0.
REQ-010 SHALL have port: pwrbus_ram_pd  input  32  passed unchanged to RAM.
REQ-011 SHALL have port, present only with SA_RAM_FIFO_LVL_EN: fifo_lvl  output  5  occupancy.

Function
REQ-012 SHALL store entries in one sa_ram_rwsp_16x256 instance:
- write: we=push, wa=wp, di=in_data.
- read: re registers ra; ore registers dout.
REQ-013 SHALL keep these 4-bit pointers, each wrapping 15->0:
- wp: write pointer.
- ip: read-issue pointer.
- rp: release pointer.
REQ-014 SHALL keep a 5-bit RAM count cnt = entries pushed but not yet released. Update per cycle: +1 on push, -1 on release, unchanged on both.
REQ-015 SHALL drive in_ready = (cnt != 16), from registered state only; a pop in the same cycle does not free a slot.
REQ-016 SHALL keep a 2-stage read pipeline:
- S1 (s1_vld): address latched in RAM.
- S2 (s2_vld): data in RAM output register.
REQ-017 SHALL drive ore = s1_vld & (~s2_vld | out_ready); an ore cycle is a release (rp++, cnt-1).
REQ-018 SHALL drive re = (ip != wp or pending-issue count > 0) & (~s1_vld | ore); ra=ip, ip++ on re. Pending-issue count is 5-bit, needed to distinguish 16-pending from 0.
REQ-019 SHALL update s1_vld <= re | (s1_vld & ~ore) and s2_vld <= ore | (s2_vld & ~out_ready).
REQ-020 SHALL drive out_valid = s2_vld and out_data = RAM dout.
REQ-021 SHALL hold the RAM address and output register unchanged while stalled, so out_data is stable while out_valid & ~out_ready.
REQ-022 SHALL have push-to-out_valid latency of exactly 3 cycles into an empty FIFO (push at t, re at t+1, ore at t+2, out_valid at t+3).
REQ-023 SHALL sustain one push and one pop per cycle when out_ready=1.
REQ-024 SHALL treat a push and an re to a slot written the previous cycle as legal; written data is visible to the read.
REQ-025 SHALL preserve FIFO order across pointer wrap.
REQ-026 SHALL ignore in_valid while in_ready=0, and SHALL NOT write the RAM.

Reset
REQ-027 SHALL, while rst=1, clear wp, ip, rp, cnt, s1_vld, s2_vld, with out_valid=0 and in_ready=1.
REQ-028 SHALL NOT reset RAM contents; RAM output is don't-care until first ore.
REQ-029 SHALL discard all in-flight entries if rst asserts mid-operation; first push after release of rst behaves as into an empty FIFO.

Configuration
REQ-030 SHALL, with SA_RAM_FIFO_LVL_EN defined:
- expose fifo_lvl = cnt + s2_vld, range 0..17.
- reset fifo_lvl to 0.
- update fifo_lvl registered, same cycle as cnt.
REQ-031 SHALL, without SA_RAM_FIFO_LVL_EN, omit the fifo_lvl port and its logic; all other behaviour identical.

Structure
REQ-032 SHALL place DEPTH, WIDTH, AW, CW and the pointer typedef (4-bit) and count typedef (5-bit) in package sa_ram_fifo_pkg.
REQ-033 SHALL have sa_ram_rwsp_16x256 as its only sub-module; all control logic is flat in sa_ram_fifo_16x256.

Verification
REQ-034 Single entry: push 0xA5..A5 at cycle 1, out_ready=1 -> out_valid=1 at cycle 4 with 0xA5..A5, then out_valid=0.
REQ-035 Fill: 18 pushes of 0..17 with out_ready=0 -> 16 RAM + 1 S2 + stall.
- in_ready=0 once cnt=16.
- then out_ready=1 -> 0..16 out in order, in_ready rises.
- 17 never accepted while in_ready=0.
REQ-036 Streaming: 40 back-to-back pushes with out_ready=1 -> 40 pops in order, one per cycle after the 3-cycle fill; pointers wrap twice.
REQ-037 Backpressure: toggle out_ready every cycle during 20-entry stream -> out_data stable whenever out_valid & ~out_ready; no loss, no duplicate.
REQ-038 Reset mid-stream: assert rst with 5 entries in flight -> out_valid=0, in_ready=1 immediately; next push 0x1 appears 3 cycles later as the sole output.
REQ-039 SA_RAM_FIFO_LVL_EN: push 3, pop 1 -> fifo_lvl reads 1,2,3 then 2; at full with S2 loaded fifo_lvl=17.
